ir_fetch: RTL and testbench
===========================

IR_FETCH -- requirements
Module: ir_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter IMM_MASK, default 16'h00F0: bit n set means opcode n (IR[15:12]) carries one trailing 16-bit immediate word.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_req  out  1  instruction-memory read request.
REQ-006 mem_addr  out  16  word address of the request.
REQ-007 mem_ack  in  1  read data valid this cycle; completes the request.
REQ-008 mem_rdata  in  16  read data, sampled when mem_req and mem_ack are both 1.
REQ-009 redirect  in  1  one-cycle pulse: discard in-flight fetch and restart at redirect_pc.
REQ-010 redirect_pc  in  16  new fetch address, sampled when redirect=1.
REQ-011 instr_ready  in  1  downstream register stage accepts the presented instruction.
REQ-012 instr_valid  out  1  IR/ImR/pc_out hold a complete instruction.
REQ-013 IR  out  16  instruction word.
REQ-014 ImR  out  16  immediate word; 16'h0000 when the opcode has no immediate.
REQ-015 pc_out  out  16  address of the IR word presented.

Function
REQ-016 FSM states SHALL be: FETCH_IR, FETCH_IMM, PRESENT.
REQ-017 FETCH_IR: mem_req=1, mem_addr=PC; on mem_ack, latch IR<=mem_rdata and pc_out<=PC, then PC<=PC+1.
REQ-018 FETCH_IR exit: if IMM_MASK[mem_rdata[15:12]]=1, go to FETCH_IMM; otherwise set ImR<=0 and go to PRESENT.
REQ-019 FETCH_IMM: mem_req=1, mem_addr=PC; on mem_ack, latch ImR<=mem_rdata, PC<=PC+1, go to PRESENT.
REQ-020 mem_req and mem_addr SHALL be held stable from assertion until the mem_ack cycle; mem_ack with mem_req=0 SHALL be ignored.
REQ-021 PRESENT: instr_valid=1, mem_req=0; IR, ImR and pc_out stable until accepted.
REQ-022 Accept = instr_valid and instr_ready; on accept, go to FETCH_IR the next cycle (throughput: one instruction per 2 cycles minimum without immediate, with single-cycle mem_ack).
REQ-023 instr_valid SHALL be 0 in FETCH_IR and FETCH_IMM.
REQ-024 PC arithmetic SHALL be 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000, including between the IR word and its immediate.
REQ-025 redirect in any state: PC<=redirect_pc, instr_valid<=0 next cycle, go to FETCH_IR; any mem_ack in the same cycle SHALL be discarded.
REQ-026 redirect in PRESENT with instr_ready=1: the accept SHALL still occur this cycle (downstream has the instruction); redirect then applies.
REQ-027 Redirect with no outstanding fetch SHALL issue its first request, at redirect_pc, one cycle after the pulse.

Reset
REQ-028 While rst_n=0: PC=RESET_PC, state=FETCH_IR, IR=0, ImR=0, pc_out=0, instr_valid=0.
REQ-029 While rst_n=0, mem_req=0.
REQ-030 Reset asserted mid-fetch SHALL abandon the fetch with no partial IR/ImR update.
REQ-031 First request after rst_n rises SHALL be at RESET_PC on the next rising edge.

Verification
REQ-032 Reset release, memory acks every cycle, mem[0]=16'h1234 (op 1, no imm) -> instr_valid with IR=16'h1234, ImR=0, pc_out=0; next fetch at addr 1.
REQ-033 mem[0]=16'h5ABC (op 5, imm), mem[1]=16'h00FF -> IR=16'h5ABC, ImR=16'h00FF, pc_out=0; next fetch at addr 2.
REQ-034 instr_ready=0 for 5 cycles in PRESENT -> IR/ImR/pc_out unchanged, mem_req=0 throughout, no PC advance.
REQ-035 Redirect to 16'h0040 in the same cycle as mem_ack in FETCH_IMM -> ack discarded, next request addr 16'h0040, no instr_valid for the discarded instruction.
REQ-036 PC=16'hFFFF holding an imm opcode -> IR from 16'hFFFF, ImR from 16'h0000, next fetch at 16'h0001.
REQ-037 rst_n dropped while mem_req=1 awaiting ack -> mem_req=0 and instr_valid=0 immediately (asynchronously); after release, first request at RESET_PC.

Source files
------------

// File: rtl/ir_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect input and
// the instruction hand-off to the downstream register stage.
interface ir_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] IR;
  logic [15:0] ImR;
  logic [15:0] pc_out;

  modport master (
    output mem_req, mem_addr, instr_valid, IR, ImR, pc_out,
    input  mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, IR, ImR, pc_out,
    output mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ir_fetch.sv
// Instruction fetch unit: reads an instruction word plus an optional trailing
// immediate word, then holds them for the downstream stage until accepted.
module ir_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] IMM_MASK = 16'h00F0
) (
  input  logic     clk,
  input  logic     rst_n,
  ir_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH_IR, FETCH_IMM, PRESENT} state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] ir_q, ir_nx;
  logic [15:0] imr_q, imr_nx;
  logic [15:0] pco_q, pco_nx;
  logic        active;
  logic        mem_req;
  logic        take;

  // active holds requests off until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH_IR;
      active <= 1'b0;
    end else begin
      state  <= state_nx;
      active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      ir_q  <= '0;
      imr_q <= '0;
      pco_q <= '0;
    end else begin
      pc    <= pc_nx;
      ir_q  <= ir_nx;
      imr_q <= imr_nx;
      pco_q <= pco_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir_q;
    imr_nx   = imr_q;
    pco_nx   = pco_q;
    mem_req  = active && (state != PRESENT);
    // an ack coinciding with a redirect belongs to the abandoned stream
    take     = mem_req && bus.mem_ack && !bus.redirect;

    case (state)
      FETCH_IR: begin
        if (take) begin
          ir_nx  = bus.mem_rdata;
          pco_nx = pc;
          pc_nx  = pc + 16'd1;
          if (IMM_MASK[bus.mem_rdata[15:12]]) begin
            state_nx = FETCH_IMM;
          end else begin
            imr_nx   = '0;
            state_nx = PRESENT;
          end
        end
      end
      FETCH_IMM: begin
        if (take) begin
          imr_nx   = bus.mem_rdata;
          pc_nx    = pc + 16'd1;
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.instr_ready) state_nx = FETCH_IR;
      end
      default: state_nx = FETCH_IR;
    endcase

    if (bus.redirect) begin
      pc_nx    = bus.redirect_pc;
      state_nx = FETCH_IR;
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = (state == PRESENT);
  assign bus.IR          = ir_q;
  assign bus.ImR         = imr_q;
  assign bus.pc_out      = pco_q;

endmodule

// File: tb/tb_ir_fetch.sv
// Directed self-checking bench for ir_fetch with a combinational memory model.
module tb_ir_fetch;

  logic clk;
  logic rst_n;
  logic ack_en;
  logic [15:0] mem [0:65535];
  int unsigned checks;
  int unsigned errors;

  ir_fetch_if bus ();

  ir_fetch #(
    .RESET_PC (16'h0000),
    .IMM_MASK (16'h00F0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_ack   = ack_en & bus.mem_req;
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.instr_valid); end
    checks++; if (bus.IR !== 16'h0000) begin errors++; $display("FAIL reset_IR got %h exp 0000", bus.IR); end
    checks++; if (bus.ImR !== 16'h0000) begin errors++; $display("FAIL reset_ImR got %h exp 0000", bus.ImR); end
    checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc_out got %h exp 0000", bus.pc_out); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0000", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_no_imm;
    bit ok;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL noimm_timeout got no instr_valid exp instr_valid"); end
    checks++; if (bus.IR !== 16'h1234 || bus.ImR !== 16'h0000 || bus.pc_out !== 16'h0000) begin
      errors++; $display("FAIL noimm_instr got IR=%h ImR=%h pc=%h exp 1234 0000 0000", bus.IR, bus.ImR, bus.pc_out);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0001 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL noimm_next got req=%b addr=%h v=%b exp 1 0001 0", bus.mem_req, bus.mem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_imm;
    bit ok;
    mem[16'h0000] = 16'h5ABC;
    mem[16'h0001] = 16'h00FF;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL imm_timeout got no instr_valid exp instr_valid"); end
    checks++; if (bus.IR !== 16'h5ABC || bus.ImR !== 16'h00FF || bus.pc_out !== 16'h0000) begin
      errors++; $display("FAIL imm_instr got IR=%h ImR=%h pc=%h exp 5ABC 00FF 0000", bus.IR, bus.ImR, bus.pc_out);
    end
    checks++; if (bus.mem_addr !== 16'h0002) begin errors++; $display("FAIL imm_pc got %h exp 0002", bus.mem_addr); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.mem_req !== 1'b0 || bus.IR !== 16'h5ABC ||
          bus.ImR !== 16'h00FF || bus.pc_out !== 16'h0000 || bus.mem_addr !== 16'h0002) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b req=%b IR=%h ImR=%h pc=%h addr=%h exp 1 0 5ABC 00FF 0000 0002",
                 i, bus.instr_valid, bus.mem_req, bus.IR, bus.ImR, bus.pc_out, bus.mem_addr);
      end
    end
  endtask

  task automatic test_redirect_imm;
    bit ok;
    mem[16'h0002] = 16'h5111;
    mem[16'h0003] = 16'h2222;
    mem[16'h0040] = 16'h1777;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.mem_addr !== 16'h0002 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL redir_pre got addr=%h req=%b exp 0002 1", bus.mem_addr, bus.mem_req);
    end
    step();
    checks++; if (bus.mem_addr !== 16'h0003 || bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_imm_phase got addr=%h req=%b v=%b exp 0003 1 0", bus.mem_addr, bus.mem_req, bus.instr_valid);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.mem_addr !== 16'h0040 || bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_target got addr=%h req=%b v=%b exp 0040 1 0", bus.mem_addr, bus.mem_req, bus.instr_valid);
    end
    wait_valid(ok);
    checks++; if (!ok || bus.IR !== 16'h1777 || bus.ImR !== 16'h0000 || bus.pc_out !== 16'h0040) begin
      errors++; $display("FAIL redir_instr got ok=%b IR=%h ImR=%h pc=%h exp 1 1777 0000 0040", ok, bus.IR, bus.ImR, bus.pc_out);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    mem[16'hFFFF] = 16'h6ABC;
    mem[16'h0000] = 16'hBEEF;
    // redirect while accepting the presented instruction
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    bus.instr_ready = 1'b1;
    step();
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b0;
    checks++; if (bus.mem_addr !== 16'hFFFF || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL wrap_req got addr=%h req=%b exp FFFF 1", bus.mem_addr, bus.mem_req);
    end
    wait_valid(ok);
    checks++; if (!ok || bus.IR !== 16'h6ABC || bus.ImR !== 16'hBEEF || bus.pc_out !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_instr got ok=%b IR=%h ImR=%h pc=%h exp 1 6ABC BEEF FFFF", ok, bus.IR, bus.ImR, bus.pc_out);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.mem_addr !== 16'h0001 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL wrap_next got addr=%h req=%b exp 0001 1", bus.mem_addr, bus.mem_req);
    end
  endtask

  task automatic test_async_reset;
    ack_en = 1'b0;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0001) begin
      errors++; $display("FAIL areset_pending got req=%b addr=%h exp 1 0001", bus.mem_req, bus.mem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL areset_immediate got req=%b v=%b exp 0 0", bus.mem_req, bus.instr_valid);
    end
    checks++; if (bus.IR !== 16'h0000 || bus.ImR !== 16'h0000 || bus.pc_out !== 16'h0000) begin
      errors++; $display("FAIL areset_regs got IR=%h ImR=%h pc=%h exp 0000 0000 0000", bus.IR, bus.ImR, bus.pc_out);
    end
    step();
    ack_en = 1'b1;
    rst_n  = 1'b1;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL areset_first_req got req=%b addr=%h exp 1 0000", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned valids;
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h2345;
    mem[16'h0002] = 16'h3456;
    bus.instr_ready = 1'b1;
    valids = 0;
    // state is FETCH_IR at 0000 with ack every cycle: 3 instructions in 6 cycles
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.instr_valid === 1'b1) valids++;
    end
    bus.instr_ready = 1'b0;
    checks++; if (valids != 3) begin errors++; $display("FAIL b2b_rate got %0d exp 3", valids); end
    checks++; if (bus.mem_addr !== 16'h0003) begin errors++; $display("FAIL b2b_pc got %h exp 0003", bus.mem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1234;
    rst_n           = 1'b0;
    ack_en          = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.instr_ready = 1'b0;
    test_reset();
    test_no_imm();
    test_imm();
    test_stall();
    test_redirect_imm();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
